// File: rtl/accum_property_store_if.sv
// Term-stream and result-stream bundle between receiver, accumulate/store stage and updater.
// Slave modport is the stage's view; master is the driving environment's view.
interface accum_property_store_if #(
    parameter int DIMS  = 2,
    parameter int IDX_W = 7
);
    logic [16*DIMS-1:0]     term_in;
    logic                   term_valid_in;
    logic                   term_last_in;
    logic                   term_ready_out;
    logic [16*(DIMS+1)-1:0] result_out;
    logic [IDX_W-1:0]       result_index_out;
    logic                   result_valid_out;
    logic                   result_ready_in;

    modport slave (
        input  term_in, term_valid_in, term_last_in, result_ready_in,
        output term_ready_out, result_out, result_index_out, result_valid_out
    );

    modport master (
        output term_in, term_valid_in, term_last_in, result_ready_in,
        input  term_ready_out, result_out, result_index_out, result_valid_out
    );
endinterface

// File: rtl/accum_property_store.sv
// SPH density/force accumulate-and-store stage: binary16 per-lane sums, density reciprocal and
// clipped pressure stored per particle, force sums emitted with the stored reciprocal.
module accum_property_store #(
    parameter int DIMS           = 2,
    parameter int PARTICLE_COUNT = 128,
    parameter int IDX_W          = $clog2(PARTICLE_COUNT),
    parameter int CLIP_NEG       = 1
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [15:0]      pressure_const,
    input  logic [15:0]      target_density,
    input  logic             start_in,
    input  logic             mode_in,
    input  logic [IDX_W-1:0] index_in,
    output logic             start_ready_out,
    input  logic [IDX_W-1:0] lookup_index_in,
    input  logic             lookup_valid_in,
    output logic [15:0]      lookup_recip_out,
    output logic [15:0]      lookup_pressure_out,
    output logic             lookup_miss_out,
    output logic             lookup_valid_out,
    output logic             density_done_out,
    input  logic             clear_in,
    output logic             error_out,
    accum_property_store_if.slave bus
);

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] ONE  = 16'h3C00;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_DRAIN, S_POST, S_WRITE, S_FETCH, S_OUTPUT
    } state_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:0] == 15'h7C00);
    endfunction

    function automatic logic is_zero(input logic [15:0] x);
        return (x[14:0] == 15'd0);
    endfunction

    // Finite operand as integer significand m scaled by 2^e.
    function automatic void fp_unpack(input logic [15:0] x, output logic [10:0] m, output int e);
        if (x[14:10] == 5'd0) begin
            m = {1'b0, x[9:0]};
            e = -24;
        end else begin
            m = {1'b1, x[9:0]};
            e = int'(x[14:10]) - 25;
        end
    endfunction

    // Rounds the exact value mm * 2^e to binary16, nearest-even, with subnormals and overflow.
    function automatic logic [15:0] fp_pack(input logic s, input int e, input logic [47:0] mm);
        int          p, big_e, sh, base, r;
        logic [47:0] kept, rem, half;
        if (mm == '0) return {s, 15'd0};
        p = 0;
        for (int i = 0; i < 48; i++) if (mm[i]) p = i;
        big_e = e + p;
        if (big_e > 15) return {s, 15'h7C00};
        if (big_e >= -14) begin
            base = big_e + 14;
            sh   = p - 10;
        end else begin
            base = 0;
            sh   = -24 - e;
        end
        if (sh > 47) return {s, 15'd0};
        if (sh > 0) begin
            kept = mm >> sh;
            rem  = mm & ((48'd1 << sh) - 48'd1);
            half = 48'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 48'd1;
        end else begin
            kept = mm << (-sh);
        end
        // The hidden bit carries into the exponent field, so rounding overflow needs no fix-up.
        r = (base << 10) + int'(kept[11:0]);
        if (r >= 'h7C00) return {s, 15'h7C00};
        return {s, r[14:0]};
    endfunction

    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic [10:0] ma, mb;
        int          ea, eb, emin;
        logic [47:0] xa, xb;
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) && is_inf(b) && (a[15] != b[15])) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        fp_unpack(a, ma, ea);
        fp_unpack(b, mb, eb);
        emin = (ea < eb) ? ea : eb;
        xa   = 48'(ma) << (ea - emin);
        xb   = 48'(mb) << (eb - emin);
        if (a[15] == b[15]) return fp_pack(a[15], emin, xa + xb);
        if (xa > xb) return fp_pack(a[15], emin, xa - xb);
        if (xb > xa) return fp_pack(b[15], emin, xb - xa);
        return 16'h0000;
    endfunction

    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic [10:0] ma, mb;
        int          ea, eb;
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a) || is_inf(b)) begin
            if (is_zero(a) || is_zero(b)) return QNAN;
            return {a[15] ^ b[15], 15'h7C00};
        end
        fp_unpack(a, ma, ea);
        fp_unpack(b, mb, eb);
        return fp_pack(a[15] ^ b[15], ea + eb, 48'(ma) * 48'(mb));
    endfunction

    // Long division keeps 23+ quotient bits; the remainder folds into a sticky LSB.
    function automatic logic [15:0] fp_div(input logic [15:0] a, input logic [15:0] b);
        logic [10:0] ma, mb;
        int          ea, eb;
        logic [47:0] num, q, rem;
        if (is_nan(a) || is_nan(b)) return QNAN;
        if (is_inf(a)) return is_inf(b) ? QNAN : {a[15] ^ b[15], 15'h7C00};
        if (is_inf(b)) return {a[15] ^ b[15], 15'd0};
        if (is_zero(b)) return is_zero(a) ? QNAN : {a[15] ^ b[15], 15'h7C00};
        fp_unpack(a, ma, ea);
        fp_unpack(b, mb, eb);
        num = 48'(ma) << 34;
        q   = num / 48'(mb);
        rem = num % 48'(mb);
        return fp_pack(a[15] ^ b[15], ea - eb - 35, {q[46:0], |rem});
    endfunction

    state_t                state_q, state_d;
    logic                  step_q;
    logic                  mode_q;
    logic [IDX_W-1:0]      idx_q;
    logic [15:0]           pconst_q, target_q;
    logic [16*DIMS-1:0]    acc_q;
    logic [15:0]           recip_q, diff_q, press_q;
    logic                  error_q;
    logic [PARTICLE_COUNT-1:0] bitmap_q;
    logic [31:0]           mem [PARTICLE_COUNT];
    logic [31:0]           lk_word_q;
    logic [15:0]           fetch_recip_q;
    logic                  lk_req_q, lk_hit_q;
    logic                  lk_valid_q, lk_miss_q;
    logic [15:0]           lk_recip_q, lk_press_q;
    logic                  term_fire, start_fire;
    logic [15:0]           press_raw;

    assign term_fire  = bus.term_valid_in && (state_q == S_ACCUM);
    assign start_fire = start_in && (state_q == S_IDLE);
    assign press_raw  = fp_mul(diff_q, pconst_q);

    // NOTE: every sequential process uses non-blocking assignments so all registers sample
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_in) state_d = S_ACCUM;
            S_ACCUM:  if (term_fire && bus.term_last_in) state_d = S_DRAIN;
            S_DRAIN:  state_d = mode_q ? S_FETCH : S_POST;
            S_POST:   if (step_q) state_d = S_WRITE;
            S_WRITE:  state_d = S_IDLE;
            S_FETCH:  if (step_q) state_d = S_OUTPUT;
            S_OUTPUT: if (bus.result_ready_in) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: each output gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        start_ready_out      = 1'b0;
        bus.term_ready_out   = 1'b0;
        bus.result_valid_out = 1'b0;
        density_done_out     = 1'b0;
        case (state_q)
            S_IDLE:   start_ready_out      = 1'b1;
            S_ACCUM:  bus.term_ready_out   = 1'b1;
            S_WRITE:  density_done_out     = 1'b1;
            S_OUTPUT: bus.result_valid_out = 1'b1;
            default:  ;
        endcase
    end

    assign bus.result_out       = {acc_q, recip_q};
    assign bus.result_index_out = idx_q;
    assign error_out            = error_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= 1'b0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            pconst_q <= '0;
            target_q <= '0;
            acc_q    <= '0;
            recip_q  <= '0;
            diff_q   <= '0;
            press_q  <= '0;
            error_q  <= 1'b0;
            bitmap_q <= '0;
        end else begin
            if (start_fire) begin
                mode_q   <= mode_in;
                idx_q    <= index_in;
                pconst_q <= pressure_const;
                target_q <= target_density;
                acc_q    <= '0;
            end
            // Single-stage accumulator per lane: no partial sums outlive the last term.
            if (term_fire) begin
                for (int l = 0; l < DIMS; l++)
                    acc_q[16*l +: 16] <= fp_add(acc_q[16*l +: 16], bus.term_in[16*l +: 16]);
            end
            if ((state_q == S_POST) && !step_q) begin
                recip_q <= fp_div(ONE, acc_q[15:0]);
                diff_q  <= fp_add(acc_q[15:0], {~target_q[15], target_q[14:0]});
            end
            if ((state_q == S_POST) && step_q)
                press_q <= ((CLIP_NEG != 0) && press_raw[15]) ? 16'h0000 : press_raw;
            if ((state_q == S_FETCH) && step_q)
                recip_q <= bitmap_q[idx_q] ? fetch_recip_q : 16'h0000;
            step_q <= ((state_q == S_POST) || (state_q == S_FETCH)) ? ~step_q : 1'b0;
            if (state_q == S_WRITE)
                bitmap_q[idx_q] <= 1'b1;
            else if (clear_in && (state_q == S_IDLE))
                bitmap_q <= '0;
            if ((start_in && (state_q != S_IDLE)) ||
                (bus.term_valid_in && (state_q != S_ACCUM)) ||
                (clear_in && (state_q != S_IDLE)))
                error_q <= 1'b1;
        end
    end

    // NOTE: the storage array and its read registers carry no reset; the written bitmap
    // masks stale contents, and the reset-visible lookup outputs sit one stage later.
    always_ff @(posedge clk_in) begin
        if (state_q == S_WRITE) mem[idx_q] <= {press_q, recip_q};
        lk_word_q     <= mem[lookup_index_in];
        fetch_recip_q <= mem[idx_q][15:0];
    end

    // Two-stage read-first lookup: stage 1 samples storage and bitmap, stage 2 drives outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lk_req_q   <= 1'b0;
            lk_hit_q   <= 1'b0;
            lk_valid_q <= 1'b0;
            lk_miss_q  <= 1'b0;
            lk_recip_q <= '0;
            lk_press_q <= '0;
        end else begin
            lk_req_q   <= lookup_valid_in;
            lk_hit_q   <= bitmap_q[lookup_index_in];
            lk_valid_q <= lk_req_q;
            if (lk_req_q) begin
                lk_recip_q <= lk_hit_q ? lk_word_q[15:0]  : 16'h0000;
                lk_press_q <= lk_hit_q ? lk_word_q[31:16] : 16'h0000;
                lk_miss_q  <= ~lk_hit_q;
            end
        end
    end

    assign lookup_recip_out    = lk_recip_q;
    assign lookup_pressure_out = lk_press_q;
    assign lookup_miss_out     = lk_miss_q;
    assign lookup_valid_out    = lk_valid_q;

endmodule

// File: tb/tb_accum_property_store.sv
// Directed bench for accum_property_store: one clipping and one non-clipping instance share stimulus.
module tb_accum_property_store;
    localparam int DIMS  = 2;
    localparam int IDX_W = 7;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [15:0]      target;
        logic [15:0]      pconst;
        logic [15:0]      term;
        int               nterms;
        logic [15:0]      recip;
        logic [15:0]      press_clip;
        logic [15:0]      press_raw;
    } dvec_t;

    logic             clk, rst_n;
    logic [15:0]      pressure_const, target_density;
    logic             start_in, mode_in, clear_in, lookup_valid_in;
    logic [IDX_W-1:0] index_in, lookup_index_in;

    logic             a_start_ready, a_done, a_error, a_lk_miss, a_lk_valid;
    logic [15:0]      a_lk_recip, a_lk_press;
    logic             b_start_ready, b_done, b_error, b_lk_miss, b_lk_valid;
    logic [15:0]      b_lk_recip, b_lk_press;

    int total = 0;
    int bad   = 0;

    accum_property_store_if #(.DIMS(DIMS), .IDX_W(IDX_W)) bus1 ();
    accum_property_store_if #(.DIMS(DIMS), .IDX_W(IDX_W)) bus0 ();

    assign bus0.term_in         = bus1.term_in;
    assign bus0.term_valid_in   = bus1.term_valid_in;
    assign bus0.term_last_in    = bus1.term_last_in;
    assign bus0.result_ready_in = bus1.result_ready_in;

    accum_property_store #(.DIMS(DIMS), .PARTICLE_COUNT(128), .IDX_W(IDX_W), .CLIP_NEG(1)) dut_a (
        .clk_in(clk), .rst_n(rst_n), .pressure_const(pressure_const), .target_density(target_density),
        .start_in(start_in), .mode_in(mode_in), .index_in(index_in), .start_ready_out(a_start_ready),
        .lookup_index_in(lookup_index_in), .lookup_valid_in(lookup_valid_in),
        .lookup_recip_out(a_lk_recip), .lookup_pressure_out(a_lk_press), .lookup_miss_out(a_lk_miss),
        .lookup_valid_out(a_lk_valid), .density_done_out(a_done), .clear_in(clear_in),
        .error_out(a_error), .bus(bus1)
    );

    accum_property_store #(.DIMS(DIMS), .PARTICLE_COUNT(128), .IDX_W(IDX_W), .CLIP_NEG(0)) dut_b (
        .clk_in(clk), .rst_n(rst_n), .pressure_const(pressure_const), .target_density(target_density),
        .start_in(start_in), .mode_in(mode_in), .index_in(index_in), .start_ready_out(b_start_ready),
        .lookup_index_in(lookup_index_in), .lookup_valid_in(lookup_valid_in),
        .lookup_recip_out(b_lk_recip), .lookup_pressure_out(b_lk_press), .lookup_miss_out(b_lk_miss),
        .lookup_valid_out(b_lk_valid), .density_done_out(b_done), .clear_in(clear_in),
        .error_out(b_error), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic m, input logic [IDX_W-1:0] idx,
                               input logic [15:0] tgt, input logic [15:0] pc);
        int n;
        n = 0;
        while (!a_start_ready && n < 40) begin tick(); n++; end
        check("start_ready_before_frame", a_start_ready, 1);
        mode_in = m; index_in = idx; target_density = tgt; pressure_const = pc;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        target_density = 16'h7BFF;
        pressure_const = 16'h7BFF;
    endtask

    task automatic send_terms(input logic [31:0] term, input int n);
        for (int i = 0; i < n; i++) begin
            bus1.term_in       = term;
            bus1.term_valid_in = 1'b1;
            bus1.term_last_in  = (i == n - 1);
            tick();
        end
        bus1.term_valid_in = 1'b0;
        bus1.term_last_in  = 1'b0;
    endtask

    task automatic wait_done(input bit collide, input logic [IDX_W-1:0] cidx);
        int n;
        n = 0;
        while (!a_done && n < 40) begin tick(); n++; end
        check("density_done_seen", a_done, 1);
        if (collide) begin
            lookup_index_in = cidx;
            lookup_valid_in = 1'b1;
        end
        tick();
        lookup_valid_in = 1'b0;
        check("density_done_one_cycle", a_done, 0);
        if (collide) begin
            tick();
            check("collide_valid", a_lk_valid, 1);
            check("collide_old_miss", a_lk_miss, 1);
            check("collide_old_recip", a_lk_recip, 16'h0000);
            check("collide_old_press", a_lk_press, 16'h0000);
        end
    endtask

    task automatic do_lookup(input string tag, input logic [IDX_W-1:0] idx, input logic [15:0] er,
                             input logic [15:0] epc, input logic [15:0] epr, input logic em);
        lookup_index_in = idx;
        lookup_valid_in = 1'b1;
        tick();
        lookup_valid_in = 1'b0;
        check({tag, "_valid_early"}, a_lk_valid, 0);
        tick();
        check({tag, "_valid"}, a_lk_valid, 1);
        check({tag, "_recip"}, a_lk_recip, er);
        check({tag, "_press"}, a_lk_press, epc);
        check({tag, "_miss"}, a_lk_miss, em);
        check({tag, "_press_noclip"}, b_lk_press, epr);
        check({tag, "_miss_noclip"}, b_lk_miss, em);
    endtask

    dvec_t vecs[6];
    logic [47:0] held;

    initial begin
        vecs[0] = '{7'd5,   16'h4000, 16'h3C00, 16'h3C00, 4, 16'h3400, 16'h4000, 16'h4000};
        vecs[1] = '{7'd6,   16'h4000, 16'h3C00, 16'h3C00, 1, 16'h3C00, 16'h0000, 16'hBC00};
        vecs[2] = '{7'd9,   16'h0000, 16'h4000, 16'h4000, 2, 16'h3400, 16'h4800, 16'h4800};
        vecs[3] = '{7'd10,  16'h3C00, 16'h3C00, 16'h0000, 3, 16'h7C00, 16'h0000, 16'hBC00};
        vecs[4] = '{7'd127, 16'h3800, 16'h4200, 16'h3800, 1, 16'h4000, 16'h0000, 16'h0000};
        vecs[5] = '{7'd0,   16'h3C00, 16'h3800, 16'h4200, 1, 16'h3555, 16'h3C00, 16'h3C00};

        rst_n = 1'b0; start_in = 1'b0; mode_in = 1'b0; clear_in = 1'b0; lookup_valid_in = 1'b0;
        index_in = '0; lookup_index_in = '0; pressure_const = '0; target_density = '0;
        bus1.term_in = '0; bus1.term_valid_in = 1'b0; bus1.term_last_in = 1'b0;
        bus1.result_ready_in = 1'b0;
        #12;
        check("rst_start_ready", a_start_ready, 1);
        check("rst_term_ready", bus1.term_ready_out, 0);
        check("rst_result_valid", bus1.result_valid_out, 0);
        check("rst_result", bus1.result_out, 0);
        check("rst_error", a_error, 0);
        check("rst_lk_valid", a_lk_valid, 0);
        rst_n = 1'b1;
        tick();
        do_lookup("init_lk5", 7'd5, 16'h0000, 16'h0000, 16'h0000, 1'b1);

        for (int i = 0; i < 6; i++) begin
            start_frame(1'b0, vecs[i].idx, vecs[i].target, vecs[i].pconst);
            check("term_ready_in_accum", bus1.term_ready_out, 1);
            send_terms({16'h5555, vecs[i].term}, vecs[i].nterms);
            wait_done(1'b0, '0);
            do_lookup($sformatf("vec%0d", i), vecs[i].idx, vecs[i].recip,
                      vecs[i].press_clip, vecs[i].press_raw, 1'b0);
        end

        // Force frame on idx 5: lane1 0.5+0.5, lane0 1+1, plus stored reciprocal.
        start_frame(1'b1, 7'd5, 16'h0000, 16'h0000);
        send_terms({16'h3800, 16'h3C00}, 2);
        begin
            int n;
            n = 0;
            while (!bus1.result_valid_out && n < 40) begin tick(); n++; end
        end
        check("force_valid_seen", bus1.result_valid_out, 1);
        check("force_result", bus1.result_out, 48'h3C00_4000_3400);
        check("force_index", bus1.result_index_out, 7'd5);
        check("force_result_noclip", bus0.result_out, 48'h3C00_4000_3400);
        held = bus1.result_out;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("force_hold_valid", bus1.result_valid_out, 1);
            check("force_hold_data", bus1.result_out, held);
            check("force_hold_start_ready", a_start_ready, 0);
        end
        bus1.result_ready_in = 1'b1;
        tick();
        bus1.result_ready_in = 1'b0;
        check("force_after_hs_idle", a_start_ready, 1);
        check("force_after_hs_valid", bus1.result_valid_out, 0);
        check("error_clean_so_far", a_error, 0);

        // Protocol errors: stray term in IDLE, then a second start inside ACCUM.
        bus1.term_in = {16'h5555, 16'h4400};
        bus1.term_valid_in = 1'b1;
        tick();
        bus1.term_valid_in = 1'b0;
        check("err_term_in_idle", a_error, 1);
        start_frame(1'b0, 7'd11, 16'h3C00, 16'h3C00);
        mode_in = 1'b1; index_in = 7'd12; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("err_start_keeps_accum", bus1.term_ready_out, 1);
        send_terms({16'h5555, 16'h3C00}, 2);
        wait_done(1'b0, '0);
        do_lookup("proto_lk11", 7'd11, 16'h3800, 16'h3C00, 16'h3C00, 1'b0);
        do_lookup("proto_lk12", 7'd12, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        check("err_sticky", a_error, 1);

        // Read-first collision on idx 7 during its WRITE cycle.
        start_frame(1'b0, 7'd7, 16'h4000, 16'h3C00);
        send_terms({16'h5555, 16'h4400}, 1);
        wait_done(1'b1, 7'd7);
        do_lookup("collide_new", 7'd7, 16'h3400, 16'h4000, 16'h4000, 1'b0);

        // Asynchronous reset mid-ACCUM, between clock edges.
        start_frame(1'b0, 7'd20, 16'h3C00, 16'h3C00);
        bus1.term_in = {16'h5555, 16'h3C00};
        bus1.term_valid_in = 1'b1;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_start_ready", a_start_ready, 1);
        check("arst_term_ready", bus1.term_ready_out, 0);
        check("arst_result_valid", bus1.result_valid_out, 0);
        check("arst_result", bus1.result_out, 0);
        check("arst_result_index", bus1.result_index_out, 0);
        check("arst_done", a_done, 0);
        check("arst_error", a_error, 0);
        check("arst_lk_valid", a_lk_valid, 0);
        bus1.term_valid_in = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        do_lookup("arst_lk5", 7'd5, 16'h0000, 16'h0000, 16'h0000, 1'b1);

        // Clear in IDLE empties the bitmap without flagging an error.
        start_frame(1'b0, vecs[2].idx, vecs[2].target, vecs[2].pconst);
        send_terms({16'h5555, vecs[2].term}, vecs[2].nterms);
        wait_done(1'b0, '0);
        do_lookup("clr_pre", 7'd9, 16'h3400, 16'h4800, 16'h4800, 1'b0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check("clr_no_error", a_error, 0);
        do_lookup("clr_post", 7'd9, 16'h0000, 16'h0000, 16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
